// File: rtl/div_4_if.sv
// Purpose : handshake and operand/result bundle for the div_4 restoring divider.
// Signals : init (start request), A/B (dividend/divisor), Q/R (quotient/remainder),
//           done (one-cycle completion pulse), div_zero (only with DIVZERO_FLAG_EN).
// Modports: master drives init/A/B; slave (the divider) drives Q/R/done/div_zero.
// Config  : DIVZERO_FLAG_EN adds the div_zero signal.
interface div_4_if #(
  parameter int unsigned WIDTH = 4
);
  logic             init;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
`ifdef DIVZERO_FLAG_EN
  logic             div_zero;

  modport master (output init, A, B, input Q, R, done, div_zero);
  modport slave  (input init, A, B, output Q, R, done, div_zero);
`else
  modport master (output init, A, B, input Q, R, done);
  modport slave  (input init, A, B, output Q, R, done);
`endif
endinterface

// File: rtl/div_4.sv
// Purpose : sequential unsigned restoring divider, one quotient bit per clock.
//           IDLE -> LOAD -> ITER (WIDTH cycles) -> DONE -> IDLE; a zero divisor
//           skips ITER and returns Q = all ones, R = A.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-low reset
//           bus  - div_4_if slave modport (init, A, B in; Q, R, done, div_zero out)
// Config  : DIVZERO_FLAG_EN enables the registered div_zero flag.
module div_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  div_4_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_init_q;
  logic [WIDTH-1:0] r_dvd;    // dividend shifts out MSB-first, quotient bits shift in at LSB
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;    // restored remainder always < divisor, so WIDTH bits suffice
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;
`ifdef DIVZERO_FLAG_EN
  logic             r_div_zero;
`endif

  logic             w_start;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // Start edge detect and one restoring step on the WIDTH+1 bit working remainder.
  always_comb begin
    w_start    = bus.init & ~r_init_q;
    w_shift    = {r_rem, r_dvd[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dvs};
    w_rem_next = w_shift[WIDTH-1:0];
    w_q_next   = {r_dvd[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      w_rem_next = w_trial[WIDTH-1:0];
      w_q_next   = {r_dvd[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with datapath and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_init_q   <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
`ifdef DIVZERO_FLAG_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_init_q <= bus.init;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_dvd <= bus.A;
          r_dvs <= bus.B;
          r_rem <= '0;
          r_cnt <= CNT_W'(WIDTH);
          if (bus.B == '0) begin
            // Zero divisor: publish the fixed result now, DONE follows directly.
            r_q        <= '1;
            r_r        <= bus.A;
            r_done     <= 1'b1;
`ifdef DIVZERO_FLAG_EN
            r_div_zero <= 1'b1;
`endif
            r_state    <= S_DONE;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_dvd <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_q        <= w_q_next;
            r_r        <= w_rem_next;
            r_done     <= 1'b1;
`ifdef DIVZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.done = r_done;
`ifdef DIVZERO_FLAG_EN
  assign bus.div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_div_4.sv
// Purpose : self-checking bench for div_4 at WIDTH=4 and WIDTH=8 against an
//           arithmetic reference (a/b, a%b, fixed latency, zero-divisor rule).
// Config  : honours DIVZERO_FLAG_EN for the div_zero checks.
module tb_div_4;

  logic clk = 1'b0;
  logic rst;

  div_4_if #(.WIDTH(4)) if4();
  div_4_if #(.WIDTH(8)) if8();

  div_4 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  div_4 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference-model view of what each DUT's Q/R/div_zero should currently hold.
  logic [15:0] m_q4, m_r4, m_q8, m_r8;
  logic        m_dz4, m_dz8;
  logic        cur_init;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic init, input logic [15:0] a, input logic [15:0] b);
    cur_init = init;
    if (w == 4) begin
      if4.init = init; if4.A = a[3:0]; if4.B = b[3:0];
    end else begin
      if8.init = init; if8.A = a[7:0]; if8.B = b[7:0];
    end
  endtask

  task automatic get_out(input int w, output logic [15:0] q, output logic [15:0] r,
                         output logic d, output logic dz);
    dz = 1'b0;
    if (w == 4) begin
      q = 16'(if4.Q); r = 16'(if4.R); d = if4.done;
`ifdef DIVZERO_FLAG_EN
      dz = if4.div_zero;
`endif
    end else begin
      q = 16'(if8.Q); r = 16'(if8.R); d = if8.done;
`ifdef DIVZERO_FLAG_EN
      dz = if8.div_zero;
`endif
    end
  endtask

  // One operation: init driven right after an edge; latency counted in edges to done.
  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit toggle, input string tag,
                       output logic [15:0] q, output logic [15:0] r);
    logic [15:0] mask, exp_q, exp_r, old_q, old_r, junk_a, junk_b;
    logic        d, dz, seen;
    int          lat, extra, exp_lat;
    mask    = (w == 4) ? 16'h000F : 16'h00FF;
    exp_q   = (b == 16'd0) ? mask : a / b;
    exp_r   = (b == 16'd0) ? a : a % b;
    exp_lat = (b == 16'd0) ? 2 : w + 2;
    old_q   = (w == 4) ? m_q4 : m_q8;
    old_r   = (w == 4) ? m_r4 : m_r8;
    junk_a  = 16'($urandom) & mask;
    junk_b  = 16'($urandom) & mask;
    set_in(w, 1'b1, a, b);
    lat = 0; seen = 1'b0; q = '0; r = '0; dz = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (toggle) begin
        case (lat)
          3: set_in(w, 1'b0, junk_a, junk_b);
          4: set_in(w, 1'b1, junk_a, junk_b);
          5: set_in(w, 1'b0, junk_a, junk_b);
          6: set_in(w, 1'b1, junk_a, junk_b);
          default: ;
        endcase
      end else if (lat == hold) begin
        set_in(w, 1'b0, (lat >= 2) ? junk_a : a, (lat >= 2) ? junk_b : b);
      end
      if (lat == 2) set_in(w, cur_init, junk_a, junk_b);
      get_out(w, q, r, d, dz);
      if (d) seen = 1'b1;
      else if (lat == 1) begin
        check({tag, "_holdq"}, 32'(q), 32'(old_q));
        check({tag, "_holdr"}, 32'(r), 32'(old_r));
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_r"}, 32'(r), 32'(exp_r));
`ifdef DIVZERO_FLAG_EN
    check({tag, "_dz"}, 32'(dz), (b == 16'd0) ? 32'd1 : 32'd0);
`endif
    if (w == 4) begin m_q4 = exp_q; m_r4 = exp_r; m_dz4 = (b == 16'd0); end
    else        begin m_q8 = exp_q; m_r8 = exp_r; m_dz8 = (b == 16'd0); end
    set_in(w, 1'b0, junk_a, junk_b);
    extra = 0;
    for (int i = 0; i < w + 4; i++) begin
      @(posedge clk); #1;
      get_out(w, old_q, old_r, d, dz);
      if (d) extra++;
    end
    check({tag, "_onedone"}, 32'(extra), 32'd0);
    check({tag, "_keepq"}, 32'(old_q), 32'(exp_q));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q, r, a, b;
    logic        d, dz;
    int          extra;
    rst = 1'b0;
    set_in(4, 1'b0, 16'd0, 16'd0);
    set_in(8, 1'b0, 16'd0, 16'd0);
    m_q4 = '0; m_r4 = '0; m_q8 = '0; m_r8 = '0; m_dz4 = 1'b0; m_dz8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    get_out(4, q, r, d, dz);
    check("rst4_q", 32'(q), 32'd0);
    check("rst4_r", 32'(r), 32'd0);
    check("rst4_done", 32'(d), 32'd0);
    check("rst4_dz", 32'(dz), 32'd0);
    get_out(8, q, r, d, dz);
    check("rst8_q", 32'(q), 32'd0);
    check("rst8_done", 32'(d), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_op(4, 16'hA, 16'h3, 2, 1'b0, "t_a_3", q, r);
    do_op(4, 16'hF, 16'h1, 1, 1'b0, "t_f_1", q, r);
    do_op(4, 16'h7, 16'h9, 3, 1'b0, "t_7_9", q, r);
    do_op(4, 16'h9, 16'h0, 1, 1'b0, "t_9_0", q, r);
    do_op(4, 16'h8, 16'h2, 2, 1'b0, "t_8_2", q, r);

    // Asynchronous reset in the middle of ITER.
    set_in(4, 1'b1, 16'h6, 16'h2);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    get_out(4, q, r, d, dz);
    check("arst_q", 32'(q), 32'd0);
    check("arst_r", 32'(r), 32'd0);
    check("arst_done", 32'(d), 32'd0);
    check("arst_dz", 32'(dz), 32'd0);
    set_in(4, 1'b0, 16'h6, 16'h2);
    m_q4 = '0; m_r4 = '0; m_q8 = '0; m_r8 = '0; m_dz4 = 1'b0; m_dz8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      get_out(4, q, r, d, dz);
      if (d) extra++;
    end
    check("arst_nodone", 32'(extra), 32'd0);
    do_op(4, 16'hC, 16'h5, 1, 1'b0, "t_c_5", q, r);

    do_op(4, 16'hD, 16'h2, 0, 1'b1, "t_toggle", q, r);

    do_op(8, 16'd200, 16'd7, 1, 1'b0, "t_200_7", q, r);

    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom_range(0, 15));
      b = 16'($urandom_range(0, 15));
      do_op(4, a, b, int'($urandom_range(1, 3)), 1'b0, "rnd4", q, r);
    end

    for (int i = 0; i < 500; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(1, 255));
      do_op(8, a, b, 1, 1'b0, "rnd8", q, r);
      check("rnd8_identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
      check("rnd8_rltb", (r < b) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
